// File: rtl/alu_seq_if.sv
// Opcode package and request/response bundle for the sequential ALU.
// The requester uses the master modport and the ALU uses the slave modport.
package cpu_types_pkg;
   typedef logic [3:0] aluop_t;
   localparam aluop_t ALU_SLL  = 4'b0000;
   localparam aluop_t ALU_SRL  = 4'b0001;
   localparam aluop_t ALU_ADD  = 4'b0010;
   localparam aluop_t ALU_SUB  = 4'b0011;
   localparam aluop_t ALU_AND  = 4'b0100;
   localparam aluop_t ALU_OR   = 4'b0101;
   localparam aluop_t ALU_XOR  = 4'b0110;
   localparam aluop_t ALU_NOR  = 4'b0111;
   localparam aluop_t ALU_MUL  = 4'b1000;
   localparam aluop_t ALU_MULU = 4'b1001;
   localparam aluop_t ALU_SLT  = 4'b1010;
   localparam aluop_t ALU_SLTU = 4'b1011;
   localparam aluop_t ALU_DIV  = 4'b1100;
   localparam aluop_t ALU_DIVU = 4'b1101;
endpackage

interface alu_seq_if #(parameter int WIDTH = 32);
   logic                  op_valid;
   logic                  op_ready;
   cpu_types_pkg::aluop_t alu_op;
   logic [WIDTH-1:0]      port_a;
   logic [WIDTH-1:0]      port_b;
   logic                  result_valid;
   logic [WIDTH-1:0]      result;
   logic [WIDTH-1:0]      result_hi;
   logic                  negative;
   logic                  zero;
   logic                  overflow;
   logic                  div_by_zero;

   modport master (
      output op_valid, alu_op, port_a, port_b,
      input  op_ready, result_valid, result, result_hi,
             negative, zero, overflow, div_by_zero
   );

   modport slave (
      input  op_valid, alu_op, port_a, port_b,
      output op_ready, result_valid, result, result_hi,
             negative, zero, overflow, div_by_zero
   );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage ALU: registered single-cycle ops plus iterative shift-add
// multiply and restoring divide, stalling the requester via op_ready.
module alu_seq
   import cpu_types_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic      CLK,
   input logic      RST,
   alu_seq_if.slave bus
);
   localparam int M = WIDTH - 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;

   logic [1:0]       state;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_hi;     // partial product high / partial remainder
   logic [WIDTH-1:0] acc_lo;     // multiplier / dividend shifting into quotient
   logic             neg_lo, neg_hi, mul_sgn, div_ovf;

   aluop_t           op;
   logic [WIDTH-1:0] a, b;
   logic             fire, is_mul, is_div, is_sgn, go_mul, go_div;
   logic [WIDTH-1:0] abs_a, abs_b;

   assign op = bus.alu_op;
   assign a  = bus.port_a;
   assign b  = bus.port_b;

   assign bus.op_ready = (state == S_IDLE);
   assign fire   = bus.op_valid && (state == S_IDLE);
   assign is_mul = (op == ALU_MUL) || (op == ALU_MULU);
   assign is_div = (op == ALU_DIV) || (op == ALU_DIVU);
   assign is_sgn = (op == ALU_MUL) || (op == ALU_DIV);
   assign go_mul = fire && is_mul;
   // A zero divisor never enters DIV; it resolves as a single-cycle op.
   assign go_div = fire && is_div && (b != '0);
   assign abs_a  = (is_sgn && a[M]) ? -a : a;
   assign abs_b  = (is_sgn && b[M]) ? -b : b;

   // Single-cycle results
   logic [WIDTH-1:0] sum, diff, sc_res, sc_hi;
   logic             sc_ovf, sc_dbz;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      sc_res = '0;
      sc_hi  = '0;
      sc_ovf = 1'b0;
      sc_dbz = 1'b0;
      case (op)
         ALU_SLL:  sc_res = b << a[SHW-1:0];
         ALU_SRL:  sc_res = b >> a[SHW-1:0];
         ALU_ADD: begin
            sc_res = sum;
            sc_ovf = (a[M] == b[M]) && (sum[M] != a[M]);
         end
         ALU_SUB: begin
            sc_res = diff;
            sc_ovf = (a[M] != b[M]) && (diff[M] != a[M]);
         end
         ALU_AND:  sc_res = a & b;
         ALU_OR:   sc_res = a | b;
         ALU_XOR:  sc_res = a ^ b;
         ALU_NOR:  sc_res = ~(a | b);
         ALU_SLT:  sc_res = WIDTH'($signed(a) < $signed(b));
         ALU_SLTU: sc_res = WIDTH'(a < b);
         ALU_DIV, ALU_DIVU: begin
            sc_res = '1;
            sc_hi  = a;
            sc_dbz = 1'b1;
         end
         default: ;
      endcase
   end

   // One shift-add multiply step
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
   assign mul_hi_nx = mul_sum[WIDTH:1];
   assign mul_lo_nx = {mul_sum[0], acc_lo[M:1]};

   // One restoring divide step; trial MSB set means the subtraction underflowed
   logic [WIDTH:0]   div_shift, div_trial;
   logic             div_ge;
   logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

   assign div_shift = {acc_hi, acc_lo[M]};
   assign div_trial = div_shift - {1'b0, opnd};
   assign div_ge    = !div_trial[WIDTH];
   assign div_hi_nx = div_ge ? div_trial[M:0] : div_shift[M:0];
   assign div_lo_nx = {acc_lo[M-1:0], div_ge};

   // Sign fix-up of the final magnitudes
   logic [2*WIDTH-1:0] prod, prod_f;
   logic [WIDTH-1:0]   quo_f, rem_f, prod_hi, prod_lo;

   assign prod    = {mul_hi_nx, mul_lo_nx};
   assign prod_f  = neg_lo ? -prod : prod;
   assign prod_hi = prod_f[2*WIDTH-1:WIDTH];
   assign prod_lo = prod_f[M:0];
   assign quo_f   = neg_lo ? -div_lo_nx : div_lo_nx;
   assign rem_f   = neg_hi ? -div_hi_nx : div_hi_nx;

   logic             out_load, out_ovf, out_dbz;
   logic [WIDTH-1:0] out_res, out_hi;

   always_comb begin
      out_load = 1'b0;
      out_res  = sc_res;
      out_hi   = sc_hi;
      out_ovf  = sc_ovf;
      out_dbz  = sc_dbz;
      if (state == S_IDLE) begin
         out_load = fire && !go_mul && !go_div;
      end else if (&cnt) begin
         out_load = 1'b1;
         out_dbz  = 1'b0;
         if (state == S_MUL) begin
            out_res = prod_lo;
            out_hi  = prod_hi;
            out_ovf = mul_sgn ? (prod_hi != {WIDTH{prod_lo[M]}}) : (prod_hi != '0);
         end else begin
            out_res = quo_f;
            out_hi  = rem_f;
            out_ovf = div_ovf;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         cnt     <= '0;
         opnd    <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         neg_lo  <= 1'b0;
         neg_hi  <= 1'b0;
         mul_sgn <= 1'b0;
         div_ovf <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (go_mul || go_div) begin
                  state   <= go_mul ? S_MUL : S_DIV;
                  cnt     <= '0;
                  acc_hi  <= '0;
                  opnd    <= go_mul ? abs_a : abs_b;
                  acc_lo  <= go_mul ? abs_b : abs_a;
                  neg_lo  <= is_sgn && (a[M] ^ b[M]);
                  neg_hi  <= is_sgn && a[M];
                  mul_sgn <= is_sgn;
                  div_ovf <= (op == ALU_DIV) && (a == {1'b1, {M{1'b0}}}) && (b == '1);
               end
            end
            S_MUL: begin
               acc_hi <= mul_hi_nx;
               acc_lo <= mul_lo_nx;
               cnt    <= cnt + SHW'(1);
               if (&cnt) state <= S_IDLE;
            end
            S_DIV: begin
               acc_hi <= div_hi_nx;
               acc_lo <= div_lo_nx;
               cnt    <= cnt + SHW'(1);
               if (&cnt) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         bus.result_valid <= 1'b0;
         bus.result       <= '0;
         bus.result_hi    <= '0;
         bus.negative     <= 1'b0;
         bus.zero         <= 1'b1;
         bus.overflow     <= 1'b0;
         bus.div_by_zero  <= 1'b0;
      end else begin
         bus.result_valid <= out_load;
         if (out_load) begin
            bus.result      <= out_res;
            bus.result_hi   <= out_hi;
            bus.negative    <= out_res[M];
            bus.zero        <= (out_res == '0);
            bus.overflow    <= out_ovf;
            bus.div_by_zero <= out_dbz;
         end
      end
   end
endmodule
